// File: rtl/redmule_pkg.sv
// Shared RedMulE definitions: clock-control channel states and default timing constants.
package redmule_pkg;

    typedef enum logic [1:0] {
        CLK_OFF  = 2'd0,
        CLK_WAKE = 2'd1,
        CLK_ON   = 2'd2,
        CLK_IDLE = 2'd3
    } clk_ctrl_state_e;

    localparam int unsigned CLK_CTRL_N_CH        = 4;
    localparam int unsigned CLK_CTRL_WAKE_CYCLES = 2;
    localparam int unsigned CLK_CTRL_IDLE_CYCLES = 16;

    // One counter serves both the wake settle and the idle interval.
    function automatic int unsigned clk_ctrl_cnt_w(input int unsigned wake, input int unsigned idle);
        int unsigned m;
        m = (wake > idle) ? wake : idle;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/redmule_clk_ctrl_if.sv
// Core-side enable/offload signals and per-channel clock status of the clock controller.
interface redmule_clk_ctrl_if
    import redmule_pkg::*;
#(
    parameter int unsigned N_CH = CLK_CTRL_N_CH
);
    logic                      test_mode;
    logic                      auto_gate_en;
    logic [N_CH-1:0]           fetch_enable;
    logic [N_CH-1:0]           wake_req;
    logic [N_CH-1:0]           busy;
    logic [N_CH-1:0]           clk_en;
    logic [N_CH-1:0]           gclk;
    logic [N_CH-1:0]           ready;
    logic [$clog2(N_CH+1)-1:0] active_cnt;

    modport master (
        output test_mode, auto_gate_en, fetch_enable, wake_req, busy,
        input  clk_en, gclk, ready, active_cnt
    );

    modport slave (
        input  test_mode, auto_gate_en, fetch_enable, wake_req, busy,
        output clk_en, gclk, ready, active_cnt
    );
endinterface

// File: rtl/redmule_clk_ctrl_ch.sv
// One clock-control channel: enable FSM with wake settle, busy drain and idle auto-gating.
module redmule_clk_ctrl_ch
    import redmule_pkg::*;
#(
    parameter int unsigned WAKE_CYCLES = CLK_CTRL_WAKE_CYCLES,
    parameter int unsigned IDLE_CYCLES = CLK_CTRL_IDLE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic test_mode_i,
    input  logic auto_gate_en_i,
    input  logic fetch_enable_i,
    input  logic wake_req_i,
    input  logic busy_i,
    output logic clk_en_o,
    output logic gclk_o,
    output logic ready_o
);
    localparam int unsigned CNT_W = clk_ctrl_cnt_w(WAKE_CYCLES, IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    clk_ctrl_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CLK_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLK_OFF: begin
                if (fetch_enable_i && (!auto_gate_en_i || wake_req_i)) begin
                    state_d = CLK_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            CLK_WAKE: begin
                if (!fetch_enable_i) begin
                    state_d = CLK_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = CLK_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CLK_ON: begin
                // A dropped enable while busy keeps the clock running until the work drains.
                if (!fetch_enable_i && !busy_i) begin
                    state_d = CLK_OFF;
                    cnt_d   = '0;
                end else if (auto_gate_en_i && fetch_enable_i && !busy_i && !wake_req_i) begin
                    state_d = CLK_IDLE;
                    cnt_d   = IDLE_LOAD;
                end
            end
            CLK_IDLE: begin
                // Activity outranks expiry of the idle interval.
                if (!fetch_enable_i) begin
                    state_d = CLK_OFF;
                    cnt_d   = '0;
                end else if (busy_i || wake_req_i || !auto_gate_en_i) begin
                    state_d = CLK_ON;
                end else if (cnt_q == '0) begin
                    state_d = CLK_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = CLK_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign clk_en_o = (state_q != CLK_OFF);
    assign ready_o  = (state_q == CLK_ON) || (state_q == CLK_IDLE);

    tc_clk_gating i_clk_gate (
        .clk_i     (clk_i),
        .en_i      (clk_en_o),
        .test_en_i (test_mode_i),
        .clk_o     (gclk_o)
    );
endmodule

// File: rtl/tc_clk_gating.sv
// Behavioural latch-based clock gate: enable captured while the clock is low.
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_latch;

    always_latch begin
        if (!clk_i) en_latch = en_i | test_en_i;
    end

    assign clk_o = clk_i & en_latch;
endmodule

// File: rtl/redmule_clk_ctrl.sv
// Clock-enable sequencer for N_CH accelerator channels with active-channel count.
module redmule_clk_ctrl
    import redmule_pkg::*;
#(
    parameter int unsigned N_CH        = CLK_CTRL_N_CH,
    parameter int unsigned WAKE_CYCLES = CLK_CTRL_WAKE_CYCLES,
    parameter int unsigned IDLE_CYCLES = CLK_CTRL_IDLE_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    redmule_clk_ctrl_if.slave  bus
);
    localparam int unsigned ACT_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  clk_en;
    logic [N_CH-1:0]  gclk;
    logic [N_CH-1:0]  ready;
    logic [ACT_W-1:0] active_cnt;

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        redmule_clk_ctrl_ch #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES)
        ) i_ch (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .test_mode_i    (bus.test_mode),
            .auto_gate_en_i (bus.auto_gate_en),
            .fetch_enable_i (bus.fetch_enable[i]),
            .wake_req_i     (bus.wake_req[i]),
            .busy_i         (bus.busy[i]),
            .clk_en_o       (clk_en[i]),
            .gclk_o         (gclk[i]),
            .ready_o        (ready[i])
        );
    end

    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            active_cnt = active_cnt + ACT_W'(ready[i]);
        end
    end

    assign bus.clk_en     = clk_en;
    assign bus.gclk       = gclk;
    assign bus.ready      = ready;
    assign bus.active_cnt = active_cnt;
endmodule
